seq_divider_8bit: RTL and testbench

- Sequential restoring divider that consumes the 8-bit subtractor as its arithmetic core.
- Performs one trial subtraction per clock and produces quotient and remainder after WIDTH iterations.
- Sits downstream of the subtract stage in the arithmetic datapath.
- Start/busy/done handshake lets a controller issue one division at a time.

---
 rtl/arith_pkg.sv | 13 +
 rtl/seq_divider_8bit_div_step.sv | 25 ++
 rtl/seq_divider_8bit.sv | 106 ++++++++++
 tb/tb_seq_divider_8bit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic datapath.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned COUNT_W   = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/seq_divider_8bit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then trial subtract.
module div_step
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;

    // WIDTH+1-bit subtract as add of two's complement; the top bit is the borrow.
    always_comb begin
        r_shift = {r[WIDTH-1:0], q_msb};
        trial   = r_shift + ~{1'b0, d} + {{WIDTH{1'b0}}, 1'b1};
        q_bit   = ~trial[WIDTH];
        r_next  = q_bit ? trial : r_shift;
    end

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential restoring divider: one trial subtraction per clock, start/busy/done handshake.
module seq_divider_8bit
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [WIDTH:0]     r_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [CNT_W-1:0]   count;
    logic [WIDTH:0]     r_step;
    logic               q_bit;
    logic               accept;
    logic               last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .d      (d_reg),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == CNT_W'(1)) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                q_reg       <= dividend;
                d_reg       <= divisor;
                r_reg       <= '0;
                count       <= CNT_W'(WIDTH);
                div_by_zero <= (divisor == '0);
                // Zero divisor skips iteration, so results are published at acceptance.
                if (divisor == '0) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == RUN) begin
                r_reg <= r_step;
                q_reg <= {q_reg[WIDTH-2:0], q_bit};
                count <= count - 1'b1;
                if (last_step) begin
                    quotient  <= {q_reg[WIDTH-2:0], q_bit};
                    remainder <= r_step[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Directed self-checking bench for seq_divider_8bit.
module tb_seq_divider_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider_8bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands and start for exactly one rising edge; returns #1 after that edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    // Counts cycles after the start edge until done; optionally injects a start pulse at cycle inj.
    task automatic wait_done(input int inj, output int n, output int busy_cnt);
        n = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) busy_cnt++;
            if (n == inj) begin
                dividend = 8'd50;
                divisor  = 8'd3;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
    endtask

    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                          input logic [7:0] er, input logic edz, input int elat, input string tag);
        int n, bc;
        logic [7:0] held_q;
        issue(a, b);
        if (b != 8'd0) check(32'(div_by_zero), 32'(1'b0), {tag, "_dbz_clear"});
        wait_done(0, n, bc);
        check(32'(n), 32'(elat), {tag, "_latency"});
        check(32'(bc), 32'(elat - 1), {tag, "_busy_cycles"});
        check(32'(busy), 0, {tag, "_busy_in_done"});
        check(32'(quotient), 32'(eq), {tag, "_quotient"});
        check(32'(remainder), 32'(er), {tag, "_remainder"});
        check(32'(div_by_zero), 32'(edz), {tag, "_dbz"});
        held_q = quotient;
        @(posedge clk);
        #1;
        check(32'(done), 0, {tag, "_done_pulse"});
        check(32'(quotient), 32'(held_q), {tag, "_hold"});
    endtask

    initial begin
        int n, bc, extra;
        logic held_ok;
        rst = 1'b1;
        start = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check(32'({busy, done, quotient, remainder, div_by_zero}), 0, "reset_outputs");
        rst = 1'b0;

        do_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, "t1_200_7");

        do_div(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9, "t2_255_1");
        do_div(8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 9, "t2_5_9");
        do_div(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 9, "t2_255_255");
        do_div(8'd0,   8'd3,   8'd0,   8'd0, 1'b0, 9, "t2_0_3");

        do_div(8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1, "t3_div0");

        issue(8'd100, 8'd10);
        wait_done(3, n, bc);
        check(32'(n), 9, "t4_latency");
        check(32'(quotient), 10, "t4_quotient");
        check(32'(remainder), 0, "t4_remainder");
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        check(32'(extra), 0, "t4_no_extra_activity");

        issue(8'd200, 8'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check(32'({busy, done, quotient, remainder, div_by_zero}), 0, "t5_reset_midrun");
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        check(32'(extra), 0, "t5_no_done_after_reset");
        do_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9, "t5_9_2");

        issue(8'd200, 8'd7);
        wait_done(0, n, bc);
        check(32'(n), 9, "t6_first_latency");
        check(32'({quotient, remainder}), 32'({8'd28, 8'd4}), "t6_first_result");
        dividend = 8'd77;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        held_ok = 1'b1;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            if (quotient !== 8'd28 || remainder !== 8'd4) held_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check(32'(held_ok), 1, "t6_first_held");
        check(32'(n), 9, "t6_second_latency");
        check(32'({quotient, remainder}), 32'({8'd15, 8'd2}), "t6_second_result");

        for (int i = 0; i < 16; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 1));
            do_div(a, b, a / b, a % b, 1'b0, 9, "sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
